// File: rtl/jk_led_pkg.sv
// Shared mode encodings and the JK next-state rule for the LED bank.
// Latency: n/a (constants and a pure function).
// Backpressure: none.
package jk_led_pkg;

    localparam logic [1:0] MODE_JK_FAST = 2'b00;
    localparam logic [1:0] MODE_JK_TICK = 2'b01;
    localparam logic [1:0] MODE_COUNT   = 2'b10;
    localparam logic [1:0] MODE_HOLD    = 2'b11;

    // Classic JK behaviour: 00 hold, 01 reset, 10 set, 11 toggle.
    function automatic logic jk_next(input logic q, input logic j, input logic k);
        logic nxt;
        case ({j, k})
            2'b00:   nxt = q;
            2'b01:   nxt = 1'b0;
            2'b10:   nxt = 1'b1;
            default: nxt = ~q;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/jk_prescaler.sv
// Free-running divider producing a one-cycle tick every PRESCALE clk cycles.
// Latency: first tick PRESCALE cycles after reset release, then every PRESCALE cycles.
// Backpressure: none; runs unconditionally outside reset.
module jk_prescaler
    import jk_led_pkg::*;
#(
    parameter int PRESCALE = 12_000_000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    // A divide-by-one still needs a register bit so the width never collapses to zero.
    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] count;
    logic          at_last;

    assign at_last = (count == LAST);

    // Count 0..PRESCALE-1 and register the wrap as the tick strobe.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
            tick  <= 1'b0;
        end else begin
            tick  <= at_last;
            count <= at_last ? '0 : count + CW'(1);
        end
    end

endmodule

// File: rtl/jk_led_bank.sv
// Bank of JK flip-flops driving LEDs, with fast, ticked, counter and hold modes.
// Latency: q updates one edge after inputs (JK_FAST) or at the edge closing a tick cycle.
// Backpressure: none; inputs are sampled every edge.
module jk_led_bank
    import jk_led_pkg::*;
#(
    parameter int CHANNELS  = 4,
    parameter int PRESCALE  = 12_000_000,
    parameter int LED_CHAIN = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [1:0]          mode,
    input  logic [CHANNELS-1:0] j,
    input  logic [CHANNELS-1:0] k,
    output logic [CHANNELS-1:0] q,
    output logic [CHANNELS-1:0] led,
    output logic                tick
);

    logic [CHANNELS-1:0] jk_q;
    logic [CHANNELS-1:0] tog_en;
    logic [CHANNELS-1:0] and_chain;
    logic [CHANNELS-1:0] q_nxt;

    jk_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    // Per-channel JK next state from the current j/k inputs.
    always_comb begin
        jk_q = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            jk_q[i] = jk_next(q[i], j[i], k[i]);
        end
    end

    // Synchronous-counter toggle enables: bit i flips when all lower bits are set.
    always_comb begin
        tog_en    = '0;
        tog_en[0] = 1'b1;
        for (int i = 1; i < CHANNELS; i++) begin
            tog_en[i] = tog_en[i-1] & q[i-1];
        end
    end

    // Running AND of q from bit 0 upward for the chained LED display.
    always_comb begin
        and_chain    = '0;
        and_chain[0] = q[0];
        for (int i = 1; i < CHANNELS; i++) begin
            and_chain[i] = and_chain[i-1] & q[i];
        end
    end

    // Mode mux: the registered tick gates the slow modes at the edge closing its cycle.
    always_comb begin
        q_nxt = q;
        case (mode)
            MODE_JK_FAST: q_nxt = jk_q;
            MODE_JK_TICK: if (tick) q_nxt = jk_q;
            MODE_COUNT:   if (tick) q_nxt = q ^ tog_en;
            default:      q_nxt = q;
        endcase
    end

    // State register with synchronous clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q <= '0;
        end else begin
            q <= q_nxt;
        end
    end

    // LED drive follows q in the same cycle.
    always_comb begin
        led = (LED_CHAIN != 0) ? and_chain : q;
    end

endmodule

// File: tb/tb_jk_led_bank.sv
module tb_jk_led_bank;
    import jk_led_pkg::*;

    logic       clk;
    logic       rst_n;
    logic [1:0] mode;
    logic [3:0] j;
    logic [3:0] k;
    logic [3:0] q;
    logic [3:0] led;
    logic       tick;

    jk_led_bank #(
        .CHANNELS  (4),
        .PRESCALE  (4),
        .LED_CHAIN (1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .mode  (mode),
        .j     (j),
        .k     (k),
        .q     (q),
        .led   (led),
        .tick  (tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    // Reference state tracked by the bench.
    logic [3:0] m_q;
    logic       m_tick;
    int         m_cnt;

    typedef struct {
        logic [3:0] vj;
        logic [3:0] vk;
        logic [3:0] exp_q;
        logic [3:0] exp_led;
    } fast_vec_t;

    fast_vec_t fast_tbl [10];

    function automatic logic [3:0] led_of(input logic [3:0] v);
        logic [3:0] r;
        r[0] = v[0];
        r[1] = v[0] & v[1];
        r[2] = v[0] & v[1] & v[2];
        r[3] = &v;
        return r;
    endfunction

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance one edge, update the reference, then compare just after the edge.
    task automatic step();
        @(posedge clk);
        if (!rst_n) begin
            m_q    = 4'h0;
            m_tick = 1'b0;
            m_cnt  = 0;
        end else begin
            case (mode)
                MODE_JK_FAST: m_q = (j & ~m_q) | (~k & m_q);
                MODE_JK_TICK: if (m_tick) m_q = (j & ~m_q) | (~k & m_q);
                MODE_COUNT:   if (m_tick) m_q = m_q + 4'd1;
                default:      ;
            endcase
            m_tick = (m_cnt == 3);
            m_cnt  = (m_cnt == 3) ? 0 : m_cnt + 1;
        end
        #1;
        check("model_q", q, m_q);
        check("model_led", led, led_of(m_q));
        check("model_tick", {3'b000, tick}, {3'b000, m_tick});
    endtask

    initial begin
        int n;
        fast_tbl[0] = '{4'b0001, 4'b0000, 4'b0001, 4'b0001};
        fast_tbl[1] = '{4'b0000, 4'b0000, 4'b0001, 4'b0001};
        fast_tbl[2] = '{4'b0001, 4'b0001, 4'b0000, 4'b0000};
        fast_tbl[3] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001};
        fast_tbl[4] = '{4'b0000, 4'b0001, 4'b0000, 4'b0000};
        fast_tbl[5] = '{4'b1111, 4'b0000, 4'b1111, 4'b1111};
        fast_tbl[6] = '{4'b0000, 4'b0100, 4'b1011, 4'b0011};
        fast_tbl[7] = '{4'b1111, 4'b1111, 4'b0100, 4'b0000};
        fast_tbl[8] = '{4'b0010, 4'b0100, 4'b0010, 4'b0000};
        fast_tbl[9] = '{4'b0001, 4'b0000, 4'b0011, 4'b0011};

        m_q = 4'h0; m_tick = 1'b0; m_cnt = 0;

        // Reset holds everything at zero even with j=k=F in COUNT.
        rst_n = 1'b0; mode = MODE_COUNT; j = 4'hF; k = 4'hF;
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_q", q, 4'h0);
            check("rst_led", led, 4'h0);
            check("rst_tick", {3'b000, tick}, 4'h0);
        end
        rst_n = 1'b1; mode = MODE_HOLD;
        for (int i = 1; i <= 8; i++) begin
            step();
            check("first_ticks", {3'b000, tick}, (i == 4 || i == 8) ? 4'h1 : 4'h0);
        end

        // JK_FAST table.
        mode = MODE_JK_FAST;
        for (int i = 0; i < 10; i++) begin
            j = fast_tbl[i].vj; k = fast_tbl[i].vk;
            step();
            check("fast_q", q, fast_tbl[i].exp_q);
            check("fast_led", led, fast_tbl[i].exp_led);
        end

        // JK_TICK: align to a tick, then set between ticks.
        j = 4'h0; k = 4'hF;
        step();
        check("tick_clear", q, 4'h0);
        mode = MODE_HOLD;
        n = 0;
        while (tick !== 1'b1 && n < 8) begin step(); n++; end
        check("tick_align", {3'b000, tick}, 4'h1);
        step();
        mode = MODE_JK_TICK; j = 4'hF; k = 4'h0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("tick_wait_q", q, 4'h0);
        end
        step();
        check("tick_upd_q", q, 4'hF);
        check("tick_upd_led", led, 4'hF);

        // A switch to HOLD made during a tick cycle blocks that closing edge.
        j = 4'h0; k = 4'hF;
        step(); step(); step();
        check("sw_in_tick", {3'b000, tick}, 4'h1);
        mode = MODE_HOLD;
        step();
        check("sw_hold_q", q, 4'hF);
        mode = MODE_JK_TICK;
        for (int i = 0; i < 3; i++) begin
            step();
            check("sw_wait_q", q, 4'hF);
        end
        step();
        check("sw_upd_q", q, 4'h0);

        // COUNT from reset: 16 ticks, full wrap.
        rst_n = 1'b0; mode = MODE_COUNT; j = 4'hF; k = 4'hF;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 65; i++) begin
            step();
            if (q == 4'b0111) check("led_0111", led, 4'b0111);
            if (q == 4'b1011) check("led_1011", led, 4'b0011);
        end
        check("count_wrap_q", q, 4'h0);

        // HOLD at q=5 for 10 ticks, then resume counting.
        n = 0;
        while (m_q != 4'd5 && n < 40) begin step(); n++; end
        check("reach_q5", q, 4'd5);
        mode = MODE_HOLD;
        for (int i = 0; i < 40; i++) step();
        check("hold_q", q, 4'd5);
        mode = MODE_COUNT;
        step(); step(); step();
        check("resume_wait", q, 4'd5);
        step();
        check("resume_q6", q, 4'd6);

        // Reset mid-run at q=9 restarts the tick phase.
        n = 0;
        while (m_q != 4'd9 && n < 40) begin step(); n++; end
        check("reach_q9", q, 4'd9);
        rst_n = 1'b0;
        step();
        check("midrst_q", q, 4'h0);
        rst_n = 1'b1;
        n = 0;
        while (tick !== 1'b1 && n < 8) begin step(); n++; end
        check("midrst_tick_gap", 4'(n), 4'd4);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/jk_led_bank.md
# jk_led_bank

Parametrised bank of CHANNELS JK flip-flops driving board LEDs, with correct JK semantics (hold/reset/set/toggle), a built-in prescaler for human-visible update rates, and a free-running counter mode. It sits between the board switch/button inputs and the LED pins. It is the general replacement for the fixed four-channel LED blinker.

## Interface
- CHANNELS, 4: number of JK channels; must be ≥ 1.
- PRESCALE, 12_000_000: clk cycles per tick; must be ≥ 1.
- LED_CHAIN, 1: 1 = led[i] is the AND of q[i:0]; 0 = led[i] = q[i].
- clk  in  1  single system clock; all state changes on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- mode  in  2  00 JK_FAST, 01 JK_TICK, 10 COUNT, 11 HOLD.
- j  in  CHANNELS  per-channel J inputs.
- k  in  CHANNELS  per-channel K inputs.
- q  out  CHANNELS  flip-flop state, registered.
- led  out  CHANNELS  LED drive, combinational from q.
- tick  out  1  one-cycle prescaler strobe, registered.

## Operation
- Reset (rst_n=0 at an edge): q=0, prescaler count=0, tick=0, so led=0. Reset overrides every other input in that cycle.
- Prescaler: count runs 0..PRESCALE-1 and wraps to 0. It runs in all modes and is not cleared by a mode change. tick is registered high for exactly one cycle per wrap.
- JK rule per channel, applied when an update is enabled: j=0,k=0 hold; j=0,k=1 q←0; j=1,k=0 q←1; j=1,k=1 q←~q.
- JK_FAST: JK rule applied at every edge.
- JK_TICK: JK rule applied only at edges ending a cycle in which tick=1; otherwise hold.
- COUNT: j/k ignored. q is a CHANNELS-bit up-counter (synchronous JK counter, toggle of bit i enabled by &q[i-1:0]). It increments at edges ending a tick=1 cycle. All-ones wraps to 0.
- HOLD: q frozen; j/k ignored. The prescaler keeps running.
- led: if LED_CHAIN=1, led[i] = &q[i:0] (led[0]=q[0]); if 0, led=q.
- Mode is sampled every edge with no pipelining. A change applies at the next edge.

## Timing
- JK_FAST latency: j/k present before edge → q valid after that edge (1 cycle).
- First tick: with rst_n released before edge 0, count reaches PRESCALE-1 after PRESCALE-1 further edges. tick is high during the cycle after that, P cycles post-reset, then every PRESCALE cycles.
- PRESCALE=1: tick permanently high after the first post-reset edge. JK_TICK then behaves as JK_FAST and COUNT increments every cycle.
- JK_TICK/COUNT update occurs at the edge closing the tick=1 cycle. Inputs must be stable at that edge.
- Mode switch in a tick=1 cycle: the new mode governs that closing edge only if it was present before the edge (sampled like j/k).
- Reset mid-count or mid-tick: state clears at the next edge, and the tick phase restarts from 0.
- led follows q combinationally in the same cycle.

## Structure
- Package jk_led_pkg:
  - mode constants MODE_JK_FAST, MODE_JK_TICK, MODE_COUNT, MODE_HOLD (2-bit);
  - function jk_next(q, j, k) returning the next state.
- Sub-module jk_prescaler (params PRESCALE; ports clk, rst_n, tick). Counter width is $clog2(PRESCALE), with PRESCALE=1 handled as a 1-bit counter.
- Top holds the q register, mode mux, counter toggle-enable chain and LED AND-chain.

## Test plan
All scenarios use CHANNELS=4, PRESCALE=4.
- Reset: drive rst_n=0 with j=k=4'hF, mode=COUNT for 3 cycles → q=0, led=0, tick=0 throughout. Release → first tick high 4 cycles later, then every 4.
- JK_FAST truth table on channel 0: (j,k)=(1,0)→q0=1; (0,0)→stays 1; (1,1)→0; (1,1)→1; (0,1)→0, each one cycle after the inputs.
- JK_TICK: j=4'hF, k=0 applied between ticks → q stays 0 until the edge closing the next tick cycle, then q=4'hF. With LED_CHAIN=1, led=4'hF.
- COUNT: from reset, 16 ticks → q steps 1,2,…,15,0 at tick edges only. At q=4'b0111 with LED_CHAIN=1, led=4'b0111; at q=4'b1011, led=4'b0011.
- HOLD: at q=5 switch to HOLD for 10 ticks with j=k=4'hF → q=5. Return to COUNT → next tick gives q=6, and tick phase is unaffected by the switch.
- Reset mid-run: assert rst_n=0 for one cycle in COUNT at q=9 → q=0 next cycle, and the next tick arrives 4 cycles after release.
